pulse_profile_gen: RTL and testbench
====================================

Name: pulse_profile_gen

Overview:
Programmable pulse-train generator for the lab stimulus path. It is the parametrised successor to the fixed 32/64/128 Hz pulse generator. It provides three parameterised fixed-rate modes plus a RAM-programmed profile mode: a sequence of up to DEPTH steps, each step defining a half-period and a duration in seconds. It also supplies a run-aligned 1-second tick and a saturating pulse counter for the display logic.

Parameters:
CNT_W, 32, width of half-period and tick counters
TICK_CYC, 100000000, clk cycles per sec_tick (1 s at 100 MHz)
HALF0, 1562500, half-period in cycles for mode 0 (32 Hz)
HALF1, 781250, half-period in cycles for mode 1 (64 Hz)
HALF2, 390625, half-period in cycles for mode 2 (128 Hz)
DEPTH, 16, profile table entries (power of 2)
AW, 4, log2(DEPTH)
SEC_W, 8, step duration width in seconds
PC_W, 16, pulse counter width

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  level: 1 = run, 0 = stop
mode  in  2  0/1/2 fixed rates, 3 profile; sampled only on run entry
wr_en  in  1  profile table write strobe
wr_addr  in  AW  table entry index
wr_half  in  CNT_W  entry half-period in cycles; 0 = rest (pulse low)
wr_secs  in  SEC_W  entry duration in seconds; 0 = skip entry
prof_len  in  AW+1  number of valid entries (0..DEPTH); sampled on run entry
pulse  out  1  generated pulse train
sec_tick  out  1  one-cycle strobe every TICK_CYC cycles while running
busy  out  1  state is RUN_FIX or RUN_PROF
done  out  1  profile completed, held until start=0
step_idx  out  AW  current profile entry
pulse_count  out  PC_W  rising edges of pulse since run entry, saturating

Behaviour:
- Reset: rst is synchronous and active-high on clk. It forces IDLE; pulse, sec_tick, busy, done = 0; step_idx = 0; pulse_count = 0; internal counters = 0. Table contents are not reset.
- States:
  - IDLE: outputs low. On start=1, latch mode and prof_len, clear all counters and pulse_count, then go to RUN_FIX (mode 0-2) or RUN_PROF (mode 3) on the next cycle.
  - RUN_FIX: H = HALF[mode].
  - RUN_PROF: H = table[step_idx].half.
  - DONE: pulse=0, done=1.
- Stop: start=0 in any non-IDLE state sends the FSM to IDLE next cycle. pulse and sec_tick drop that same cycle. pulse_count holds its value until the next run entry.
- Divider: d counts 0..H-1. When d==H-1, d<=0 and pulse toggles. Pulse is low at run entry, so the first rising edge is H cycles after the FSM enters RUN. H=0 holds pulse low with d frozen. Fixed-mode HALFx must be >=1.
- Tick: s counts 0..TICK_CYC-1 from run entry. sec_tick=1 in the cycle s==TICK_CYC-1, and s wraps to 0.
- Profile stepping: the elapsed-seconds counter e increments on each sec_tick. When e reaches secs-1 on a sec_tick, the step ends.
- Step end: step_idx++, e<=0, d<=0, pulse<=0 in the same cycle.
- Entries with secs=0 are skipped, one cycle per skipped entry: step_idx++ with no output activity.
- When the incremented step_idx would equal the latched prof_len, go to DONE instead. With prof_len=0, the FSM goes RUN_PROF -> DONE on the first RUN cycle.
- pulse_count increments on each 0->1 transition of pulse and saturates at all-ones.
- Table writes: accepted only when busy=0; writes while busy are dropped. The write port is single-cycle synchronous, and the read is asynchronous or registered with no bubble at step boundaries.
- Simultaneous events:
  - rst beats everything.
  - start=0 beats step end or DONE entry.
  - A mode change mid-run is ignored until the next run entry.

Test Plan (TICK_CYC=20, HALF0=3, HALF1=2, HALF2=1, DEPTH=4):
1. rst high 2 cycles mid-run -> next cycle pulse=0, busy=0, pulse_count=0, step_idx=0, and the FSM stays IDLE while start=0.
2. mode=0, start=1 held 40 cycles -> pulse rises 3 cycles after run entry with period 6, sec_tick pulses at run cycles 19 and 39, pulse_count=7 at cycle 40.
3. Table {(2,1),(0,1),(1,2)}, prof_len=3, mode=3 -> period 4 for cycles 0-19, low for 20-39, period 2 for 40-79, then done=1, busy=0 from cycle 80 while start=1.
4. Entry 1 secs=0 in the scenario-3 table -> entry 1 skipped in 1 cycle, step_idx goes 0->1->2, entry 2 starts at cycle 21.
5. start=0 at cycle 30 of scenario 3 -> IDLE next cycle, pulse=0, pulse_count frozen. A wr_en during the run is dropped, checked by readback behaviour on the next run.
6. prof_len=0, mode=3 -> done=1 one cycle after run entry, pulse never rises, and sec_tick is never asserted.

Source files
------------

// File: rtl/pulse_profile_gen_if.sv
// Control, table-write and status bundle for pulse_profile_gen.
// The master drives run control and table writes; the slave (the generator) drives status.
interface pulse_profile_gen_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned AW    = 4,
  parameter int unsigned SEC_W = 8,
  parameter int unsigned PC_W  = 16
);
  logic             start;
  logic [1:0]       mode;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [CNT_W-1:0] wr_half;
  logic [SEC_W-1:0] wr_secs;
  logic [AW:0]      prof_len;
  logic             pulse;
  logic             sec_tick;
  logic             busy;
  logic             done;
  logic [AW-1:0]    step_idx;
  logic [PC_W-1:0]  pulse_count;

  modport master (
    output start, mode, wr_en, wr_addr, wr_half, wr_secs, prof_len,
    input  pulse, sec_tick, busy, done, step_idx, pulse_count
  );

  modport slave (
    input  start, mode, wr_en, wr_addr, wr_half, wr_secs, prof_len,
    output pulse, sec_tick, busy, done, step_idx, pulse_count
  );
endinterface

// File: rtl/pulse_profile_gen.sv
// Pulse-train generator: three fixed half-period modes plus a table-driven profile of
// (half-period, seconds) steps, with a run-aligned second tick and a saturating edge counter.
module pulse_profile_gen #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned TICK_CYC = 100000000,
  parameter int unsigned HALF0    = 1562500,
  parameter int unsigned HALF1    = 781250,
  parameter int unsigned HALF2    = 390625,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned SEC_W    = 8,
  parameter int unsigned PC_W     = 16
) (
  input logic                clk,
  input logic                rst,
  pulse_profile_gen_if.slave bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRunFix  = 2'd1;
  localparam logic [1:0] StRunProf = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  localparam logic [CNT_W-1:0] TickLast = CNT_W'(TICK_CYC - 1);
  localparam logic [AW:0]      DepthLen = (AW + 1)'(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [AW:0]      len_q, len_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] d_q, d_d;
  logic [CNT_W-1:0] s_q, s_d;
  logic [SEC_W-1:0] e_q, e_d;
  logic             pulse_q, pulse_d;
  logic [PC_W-1:0]  pc_q, pc_d;

  logic [CNT_W-1:0] tbl_half [DEPTH];
  logic [SEC_W-1:0] tbl_secs [DEPTH];

  logic             running;
  logic             tick_hit;
  logic             step_end;
  logic             last_step;
  logic [AW:0]      idx_inc;
  logic [CNT_W-1:0] fix_half;
  logic [CNT_W-1:0] cur_half;
  logic [SEC_W-1:0] cur_secs;
  logic [CNT_W-1:0] half;

  // Table has no reset; writes are only taken while no run is using it.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !running) begin
      tbl_half[bus.wr_addr] <= bus.wr_half;
      tbl_secs[bus.wr_addr] <= bus.wr_secs;
    end
  end

  assign cur_half = tbl_half[idx_q];
  assign cur_secs = tbl_secs[idx_q];

  always_comb begin
    case (mode_q)
      2'd0:    fix_half = CNT_W'(HALF0);
      2'd1:    fix_half = CNT_W'(HALF1);
      default: fix_half = CNT_W'(HALF2);
    endcase
  end

  assign running   = (state_q == StRunFix) || (state_q == StRunProf);
  assign half      = (state_q == StRunProf) ? cur_half : fix_half;
  // Stop wins over everything in the same cycle, so the tick is gated by start too.
  assign tick_hit  = running && bus.start && (s_q == TickLast);
  assign idx_inc   = {1'b0, idx_q} + (AW + 1)'(1);
  assign last_step = (idx_inc == len_q);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    idx_d    = idx_q;
    d_d      = d_q;
    s_d      = s_q;
    e_d      = e_q;
    pulse_d  = pulse_q;
    pc_d     = pc_q;
    step_end = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          len_d   = (bus.prof_len > DepthLen) ? DepthLen : bus.prof_len;
          idx_d   = '0;
          d_d     = '0;
          s_d     = '0;
          e_d     = '0;
          pulse_d = 1'b0;
          pc_d    = '0;
          state_d = (bus.mode == 2'd3) ? StRunProf : StRunFix;
        end
      end

      StRunFix, StRunProf: begin
        if (!bus.start) begin
          state_d = StIdle;
          idx_d   = '0;
          d_d     = '0;
          s_d     = '0;
          e_d     = '0;
          pulse_d = 1'b0;
        end else begin
          s_d = tick_hit ? '0 : s_q + CNT_W'(1);

          // A zero half-period is a rest: divider frozen, pulse held low.
          if (half != '0) begin
            if (d_q == half - CNT_W'(1)) begin
              d_d     = '0;
              pulse_d = !pulse_q;
            end else begin
              d_d = d_q + CNT_W'(1);
            end
          end

          if (state_q == StRunProf) begin
            if (len_q == '0) begin
              state_d = StDone;
              d_d     = '0;
              pulse_d = 1'b0;
            end else if (cur_secs == '0) begin
              step_end = 1'b1;
            end else if (tick_hit) begin
              if (e_q == cur_secs - SEC_W'(1)) begin
                step_end = 1'b1;
              end else begin
                e_d = e_q + SEC_W'(1);
              end
            end
          end

          if (step_end) begin
            e_d     = '0;
            d_d     = '0;
            pulse_d = 1'b0;
            if (last_step) begin
              state_d = StDone;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end
        end
      end

      StDone: begin
        if (!bus.start) begin
          state_d = StIdle;
          idx_d   = '0;
          s_d     = '0;
          e_d     = '0;
        end
      end

      default: state_d = StIdle;
    endcase

    if (pulse_d && !pulse_q && (pc_q != '1)) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      len_q   <= '0;
      idx_q   <= '0;
      d_q     <= '0;
      s_q     <= '0;
      e_q     <= '0;
      pulse_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      s_q     <= s_d;
      e_q     <= e_d;
      pulse_q <= pulse_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.pulse       = pulse_q && bus.start;
  assign bus.sec_tick    = tick_hit;
  assign bus.busy        = running;
  assign bus.done        = (state_q == StDone);
  assign bus.step_idx    = idx_q;
  assign bus.pulse_count = pc_q;

endmodule

// File: tb/tb_pulse_profile_gen.sv
// Scoreboard bench for pulse_profile_gen: per-cycle expectations are queued when a run is
// launched and popped as each run cycle is sampled on the falling edge.
module tb_pulse_profile_gen;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned AW    = 2;
  localparam int unsigned SEC_W = 8;
  localparam int unsigned PC_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_profile_gen_if #(.CNT_W(CNT_W), .AW(AW), .SEC_W(SEC_W), .PC_W(PC_W)) bus ();

  pulse_profile_gen #(
    .CNT_W(CNT_W), .TICK_CYC(20), .HALF0(3), .HALF1(2), .HALF2(1),
    .DEPTH(4), .AW(AW), .SEC_W(SEC_W), .PC_W(PC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit pulse;
    bit tick;
    bit busy;
    bit done;
    bit chk_idx;
    int idx;
    bit chk_pc;
    int pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  function automatic bit pulse_of(input int h, input int r);
    if (h == 0 || r < h) return 1'b0;
    return (((r - h) / h) % 2) == 0;
  endfunction

  task automatic push_exp(input bit p, input bit t, input bit b, input bit d,
                          input bit ci, input int idx, input bit cp, input int pc);
    exp_t e;
    e.pulse = p; e.tick = t; e.busy = b; e.done = d;
    e.chk_idx = ci; e.idx = idx; e.chk_pc = cp; e.pc = pc;
    sb.push_back(e);
  endtask

  // Expected trace of the three-step profile {(2,1),(0,1),(1,2)}.
  task automatic push_prof3(input int n);
    for (int c = 0; c < n; c++) begin
      if (c < 20)      push_exp(pulse_of(2, c), c == 19, 1, 0, 1, 0, c == 19, 5);
      else if (c < 40) push_exp(0, c == 39, 1, 0, 1, 1, c == 20, 5);
      else if (c < 80) push_exp(pulse_of(1, c - 40), c % 20 == 19, 1, 0, 1, 2, 0, 0);
      else             push_exp(0, 0, 0, 1, 0, 0, c == 82, 25);
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [AW:0] len);
    @(posedge clk); #1;
    bus.mode     = m;
    bus.prof_len = len;
    bus.start    = 1'b1;
  endtask

  task automatic stop_run();
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic write_entry(input int addr, input int half, input int secs);
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_half = CNT_W'(half);
    bus.wr_secs = SEC_W'(secs);
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  // Cycle c is the c-th cycle spent out of IDLE; the mode input is disturbed at c=10.
  task automatic run_check(input string name, input int n, input int stop_at, input int wr_at);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (c == stop_at) bus.start = 1'b0;
      bus.wr_en = (c == wr_at);
      if (c == wr_at) begin
        bus.wr_addr = '0;
        bus.wr_half = CNT_W'(5);
        bus.wr_secs = SEC_W'(1);
      end
      if (c == 10) bus.mode = 2'd1;
      @(negedge clk);
      check_val($sformatf("%s sb_depth c%0d", name, c), sb.size(), n - c);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_val($sformatf("%s pulse c%0d", name, c), bus.pulse, e.pulse);
        check_val($sformatf("%s sec_tick c%0d", name, c), bus.sec_tick, e.tick);
        check_val($sformatf("%s busy c%0d", name, c), bus.busy, e.busy);
        check_val($sformatf("%s done c%0d", name, c), bus.done, e.done);
        if (e.chk_idx)
          check_val($sformatf("%s step_idx c%0d", name, c), bus.step_idx, e.idx);
        if (e.chk_pc)
          check_val($sformatf("%s pulse_count c%0d", name, c), bus.pulse_count, e.pc);
      end
    end
    bus.wr_en = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 2'd0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_half = '0; bus.wr_secs = '0; bus.prof_len = '0;

    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("reset pulse", bus.pulse, 0);
    check_val("reset busy", bus.busy, 0);
    check_val("reset done", bus.done, 0);
    check_val("reset sec_tick", bus.sec_tick, 0);
    check_val("reset step_idx", bus.step_idx, 0);
    check_val("reset pulse_count", bus.pulse_count, 0);

    // Fixed mode 0: half-period 3.
    for (int c = 0; c < 41; c++)
      push_exp(pulse_of(3, c), c % 20 == 19, 1, 0, 1, 0, c == 40, 7);
    start_run(2'd0, '0);
    run_check("fix0", 41, -1, -1);

    // Synchronous reset mid-run.
    @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val($sformatf("rst pulse c%0d", c), bus.pulse, 0);
      check_val($sformatf("rst busy c%0d", c), bus.busy, 0);
      check_val($sformatf("rst pulse_count c%0d", c), bus.pulse_count, 0);
      check_val($sformatf("rst step_idx c%0d", c), bus.step_idx, 0);
    end

    write_entry(0, 2, 1);
    write_entry(1, 0, 1);
    write_entry(2, 1, 2);

    push_prof3(85);
    start_run(2'd3, 3'd3);
    run_check("prof", 85, -1, -1);
    stop_run();

    // Stop at cycle 30; a write at cycle 10 must be dropped.
    push_prof3(30);
    push_exp(0, 0, 1, 0, 1, 1, 0, 0);
    for (int c = 31; c < 36; c++) push_exp(0, 0, 0, 0, 1, 0, 1, 5);
    start_run(2'd3, 3'd3);
    run_check("stop", 36, 30, 10);
    push_prof3(22);
    start_run(2'd3, 3'd3);
    run_check("rerun", 22, -1, -1);
    stop_run();

    // Entry 1 with zero seconds is skipped in one cycle.
    write_entry(1, 0, 0);
    for (int c = 0; c < 63; c++) begin
      if (c < 20)      push_exp(pulse_of(2, c), c == 19, 1, 0, 1, 0, 0, 0);
      else if (c < 21) push_exp(0, 0, 1, 0, 1, 1, 0, 0);
      else if (c < 60) push_exp(pulse_of(1, c - 21), c % 20 == 19, 1, 0, 1, 2, 0, 0);
      else             push_exp(0, 0, 0, 1, 0, 0, c == 62, 24);
    end
    start_run(2'd3, 3'd3);
    run_check("skip", 63, -1, -1);
    stop_run();

    // Empty profile.
    for (int c = 0; c < 25; c++) push_exp(0, 0, c == 0, c != 0, 0, 0, c == 24, 0);
    start_run(2'd3, 3'd0);
    run_check("empty", 25, -1, -1);
    stop_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
